// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: input synchroniser, 3-sample majority vote per bit,
// optional parity, 1..2 stop bits, valid/ready output with overrun and break sidebands.
module uart_rx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OS        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx_d,
    input  logic                 sampling,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(OS);
    localparam int BIT_W       = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
    localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(OS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(OS / 2);
    localparam logic [CNT_W-1:0] CNT_V2   = CNT_W'(OS / 2 + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser, idles high so reset never looks like a start bit
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxd_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= i_rx_d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rxd_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t               state_reg;
    logic [CNT_W-1:0]     sample_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic                 b0_reg;
    logic                 b1_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 pbit_reg;
    logic                 perr_reg;
    logic                 stop_zero_reg;
    logic                 stop_one_reg;

    logic tick_last;
    logic vote_tick;
    logic vote;
    logic last_stop;
    logic commit;
    logic frame_err_next;
    logic break_next;
    logic perr_next;

    always_comb begin
        tick_last      = sampling && (sample_cnt_reg == CNT_LAST);
        vote_tick      = sampling && (sample_cnt_reg == CNT_V2);
        // third sample is taken live on the decision tick
        vote           = (b0_reg & b1_reg) | (b0_reg & rxd_s) | (b1_reg & rxd_s);
        last_stop      = (bit_cnt_reg == STOP_LAST);
        commit         = (state_reg == S_STOP) && vote_tick && last_stop;
        frame_err_next = stop_zero_reg | ~vote;
        break_next     = ~stop_one_reg & ~vote & (shift_reg == '0) & ~pbit_reg;
        perr_next      = (((^shift_reg) ^ vote) != (PARITY == 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            b0_reg         <= 1'b1;
            b1_reg         <= 1'b1;
            shift_reg      <= '0;
            pbit_reg       <= 1'b0;
            perr_reg       <= 1'b0;
            stop_zero_reg  <= 1'b0;
            stop_one_reg   <= 1'b0;
            o_rx_data      <= '0;
            o_rx_valid     <= 1'b0;
            o_frame_err    <= 1'b0;
            o_parity_err   <= 1'b0;
            o_break        <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            o_overrun <= 1'b0;

            if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end

            if (sampling) begin
                sample_cnt_reg <= (sample_cnt_reg == CNT_LAST) ? '0 : sample_cnt_reg + 1'b1;
                if (sample_cnt_reg == CNT_V0) begin
                    b0_reg <= rxd_s;
                end
                if (sample_cnt_reg == CNT_V1) begin
                    b1_reg <= rxd_s;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    if (sampling && !rxd_s) begin
                        state_reg      <= S_START;
                        sample_cnt_reg <= '0;
                        pbit_reg       <= 1'b0;
                        perr_reg       <= 1'b0;
                    end
                end

                S_START: begin
                    if (sampling && rxd_s && (sample_cnt_reg <= CNT_V1)) begin
                        state_reg <= S_IDLE;
                    end else if (tick_last) begin
                        state_reg   <= S_DATA;
                        bit_cnt_reg <= '0;
                    end
                end

                S_DATA: begin
                    if (vote_tick) begin
                        shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                    end
                    if (tick_last) begin
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg   <= '0;
                            stop_zero_reg <= 1'b0;
                            stop_one_reg  <= 1'b0;
                            state_reg     <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (vote_tick) begin
                        pbit_reg <= vote;
                        perr_reg <= perr_next;
                    end
                    if (tick_last) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (vote_tick) begin
                        if (last_stop) begin
                            // leave mid-bit so a following start edge is not missed
                            state_reg <= break_next ? S_BRK_WAIT : S_IDLE;
                        end else begin
                            stop_zero_reg <= stop_zero_reg | ~vote;
                            stop_one_reg  <= stop_one_reg | vote;
                        end
                    end
                    if (tick_last && !last_stop) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end

                S_BRK_WAIT: begin
                    if (sampling && rxd_s) begin
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

            // a word still held unaccepted wins over the new one
            if (commit) begin
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_data    <= shift_reg;
                    o_frame_err  <= frame_err_next;
                    o_parity_err <= (PARITY != 0) ? perr_reg : 1'b0;
                    o_break      <= break_next;
                    o_rx_valid   <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule
